// File: rtl/alt_eyemon_sweep_pkg.sv
// Shared constants and types for the eye-monitor phase-sweep master:
// slave register map, ctrl/status bit positions, error codes and FSM encodings.
package alt_eyemon_sweep_pkg;

  localparam logic [15:0] REG_CTRL = 16'd0;
  localparam logic [15:0] REG_CHAN = 16'd1;
  localparam logic [15:0] REG_WORD = 16'd2;
  localparam logic [15:0] REG_DATA = 16'd3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_READOP = 1;
  localparam int CTRL_ERR_CH = 13;
  localparam int CTRL_ERR_WD = 14;
  localparam int CTRL_BUSY   = 15;

  localparam logic [15:0] CTRL_CMD_WRITE = 16'(1 << CTRL_START);
  localparam logic [15:0] CTRL_CMD_READ  = 16'((1 << CTRL_START) | (1 << CTRL_READOP));

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_WORD_ADDR = 3'd1;
  localparam logic [2:0] ERR_CHAN_ADDR = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT   = 3'd3;
  localparam logic [2:0] ERR_READBACK  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE, ST_EN_OP, ST_STEP_OP, ST_DWELL, ST_REPORT, ST_DIS_OP, ST_DONE, ST_ERR
  } state_t;

  // Accesses within one register operation, in issue order.
  typedef enum logic [2:0] {
    SUB_CHAN, SUB_WORD, SUB_DATA, SUB_CMD, SUB_POLL, SUB_RB_CMD, SUB_RB_POLL, SUB_RB_RD
  } sub_t;

endpackage

// File: rtl/alt_eyemon_avmm_txn.sv
// Single-access Avalon-MM master: latches one request, holds it on the bus
// until waitrequest drops, then pulses ack with the captured read data.
module alt_eyemon_avmm_txn (
  input  logic        i_avmm_clk,
  input  logic        i_resetn,
  input  logic        req_i,
  input  logic        rnw_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] wdata_i,
  output logic        ack_o,
  output logic [15:0] rdata_o,
  output logic [15:0] avmm_address_o,
  output logic        avmm_read_o,
  output logic        avmm_write_o,
  output logic [15:0] avmm_writedata_o,
  input  logic [15:0] avmm_readdata_i,
  input  logic        avmm_waitrequest_i
);

  logic        ack_q;
  logic [15:0] rdata_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        read_q;
  logic        write_q;

  // Handshake: an access is live while read_q|write_q; it completes on the
  // cycle waitrequest is low, and ack_o pulses the cycle after.
  always_ff @(posedge i_avmm_clk) begin
    if (!i_resetn) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (read_q || write_q) begin
        if (!avmm_waitrequest_i) begin
          read_q  <= 1'b0;
          write_q <= 1'b0;
          ack_q   <= 1'b1;
          if (read_q) rdata_q <= avmm_readdata_i;
        end
      end else if (req_i) begin
        addr_q  <= addr_i;
        wdata_q <= rnw_i ? 16'h0000 : wdata_i;
        read_q  <= rnw_i;
        write_q <= !rnw_i;
      end
    end
  end

  assign ack_o            = ack_q;
  assign rdata_o          = rdata_q;
  assign avmm_address_o   = addr_q;
  assign avmm_read_o      = read_q;
  assign avmm_write_o     = write_q;
  assign avmm_writedata_o = wdata_q;

endmodule

// File: rtl/alt_eyemon_sweep_ctrl.sv
// Eye-monitor phase-sweep sequencer: enable, step phase 0..PHASE_MAX with dwell
// and step handshake, disable. ALT_EYEMON_SWEEP_READBACK_EN adds per-step readback.
module alt_eyemon_sweep_ctrl
  import alt_eyemon_sweep_pkg::*;
#(
  parameter int CH_W       = 3,
  parameter int PHASE_MAX  = 63,
  parameter int DWELL_W    = 16,
  parameter int POLL_LIMIT = 1024
) (
  input  logic               i_avmm_clk,
  input  logic               i_resetn,
  input  logic               i_start,
  input  logic [CH_W-1:0]    i_channel,
  input  logic [DWELL_W-1:0] i_dwell,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error,
  output logic [2:0]         o_err_code,
  output logic               o_step_valid,
  output logic [5:0]         o_step_phase,
  input  logic               i_step_ack,
  output logic [15:0]        o_avmm_maddress,
  output logic               o_avmm_mread,
  output logic               o_avmm_mwrite,
  output logic [15:0]        o_avmm_mwritedata,
  input  logic [15:0]        i_avmm_mreaddata,
  input  logic               i_avmm_mwaitrequest,
  output state_t             o_dbg_state
);

`ifdef ALT_EYEMON_SWEEP_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  localparam int         PCW        = $clog2(POLL_LIMIT + 1);
  localparam logic [PCW-1:0] POLL_LAST  = PCW'(POLL_LIMIT - 1);
  localparam logic [5:0]     PHASE_LAST = 6'(PHASE_MAX);

  state_t               state_q, state_d;
  sub_t                 sub_q, sub_d;
  logic [5:0]           phase_q, phase_d;
  logic [PCW-1:0]       poll_q, poll_d;
  logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic                 error_q, error_d;
  logic [2:0]           code_q, code_d;
  logic                 op_done;

  logic                 txn_req, txn_rnw, txn_ack;
  logic [15:0]          txn_addr, txn_wdata, txn_rdata;
  logic [15:0]          op_word, op_data;
  logic                 in_op, is_poll;

  assign in_op   = (state_q == ST_EN_OP) || (state_q == ST_STEP_OP) || (state_q == ST_DIS_OP);
  assign is_poll = (sub_q == SUB_POLL) || (sub_q == SUB_RB_POLL);

  always_ff @(posedge i_avmm_clk) begin
    if (!i_resetn) begin
      state_q     <= ST_IDLE;
      sub_q       <= SUB_CHAN;
      phase_q     <= '0;
      poll_q      <= '0;
      dwell_cnt_q <= '0;
      dwell_q     <= '0;
      ch_q        <= '0;
      error_q     <= 1'b0;
      code_q      <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      phase_q     <= phase_d;
      poll_q      <= poll_d;
      dwell_cnt_q <= dwell_cnt_d;
      dwell_q     <= dwell_d;
      ch_q        <= ch_d;
      error_q     <= error_d;
      code_q      <= code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sub_d       = sub_q;
    phase_d     = phase_q;
    poll_d      = poll_q;
    dwell_cnt_d = dwell_cnt_q;
    dwell_d     = dwell_q;
    ch_d        = ch_q;
    error_d     = error_q;
    code_d      = code_q;
    op_done     = 1'b0;
    case (state_q)
      ST_IDLE: if (i_start) begin
        state_d = ST_EN_OP;
        sub_d   = SUB_CHAN;
        ch_d    = i_channel;
        dwell_d = i_dwell;
        phase_d = '0;
        poll_d  = '0;
        error_d = 1'b0;
        code_d  = ERR_NONE;
      end
      ST_EN_OP, ST_STEP_OP, ST_DIS_OP: if (txn_ack) begin
        if (is_poll) begin
          if (txn_rdata[CTRL_BUSY]) begin
            if (poll_q == POLL_LAST) begin
              state_d = ST_ERR; error_d = 1'b1; code_d = ERR_TIMEOUT;
            end else begin
              poll_d = poll_q + 1'b1;
            end
          end else begin
            poll_d = '0;
            // Word-address error outranks channel-address error.
            if (txn_rdata[CTRL_ERR_WD]) begin
              state_d = ST_ERR; error_d = 1'b1; code_d = ERR_WORD_ADDR;
            end else if (txn_rdata[CTRL_ERR_CH]) begin
              state_d = ST_ERR; error_d = 1'b1; code_d = ERR_CHAN_ADDR;
            end else if (RB_EN && state_q == ST_STEP_OP && sub_q == SUB_POLL) begin
              sub_d = SUB_RB_CMD;
            end else if (sub_q == SUB_RB_POLL) begin
              sub_d = SUB_RB_RD;
            end else begin
              op_done = 1'b1;
            end
          end
        end else if (sub_q == SUB_RB_RD) begin
          if (txn_rdata == {10'b0, phase_q}) begin
            op_done = 1'b1;
          end else begin
            state_d = ST_ERR; error_d = 1'b1; code_d = ERR_READBACK;
          end
        end else begin
          sub_d = sub_t'(sub_q + 3'd1);
        end
      end
      ST_DWELL: begin
        if (dwell_cnt_q <= DWELL_W'(1)) state_d = ST_REPORT;
        else dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
      end
      ST_REPORT: if (i_step_ack) begin
        if (phase_q == PHASE_LAST) begin
          state_d = ST_DIS_OP;
        end else begin
          phase_d = phase_q + 6'd1;
          state_d = ST_STEP_OP;
        end
        sub_d = SUB_CHAN;
      end
      ST_ERR:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (op_done) begin
      sub_d = SUB_CHAN;
      case (state_q)
        ST_EN_OP:   state_d = ST_STEP_OP;
        ST_STEP_OP: begin state_d = ST_DWELL; dwell_cnt_d = dwell_q; end
        default:    state_d = ST_DONE;
      endcase
    end
  end

  always_comb begin
    o_busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    o_done       = (state_q == ST_DONE);
    o_step_valid = (state_q == ST_REPORT);
    op_word      = (state_q == ST_STEP_OP) ? 16'd1 : 16'd0;
    op_data      = (state_q == ST_STEP_OP) ? {10'b0, phase_q} :
                   (state_q == ST_EN_OP)   ? 16'd1 : 16'd0;
    // ack gating stops a duplicate request in the cycle the FSM advances.
    txn_req      = in_op && !txn_ack;
    txn_rnw      = 1'b0;
    txn_addr     = REG_CTRL;
    txn_wdata    = 16'h0000;
    case (sub_q)
      SUB_CHAN:    begin txn_addr = REG_CHAN; txn_wdata = 16'(ch_q); end
      SUB_WORD:    begin txn_addr = REG_WORD; txn_wdata = op_word; end
      SUB_DATA:    begin txn_addr = REG_DATA; txn_wdata = op_data; end
      SUB_CMD:     txn_wdata = CTRL_CMD_WRITE;
      SUB_RB_CMD:  txn_wdata = CTRL_CMD_READ;
      SUB_RB_RD:   begin txn_addr = REG_DATA; txn_rnw = 1'b1; end
      default:     txn_rnw = 1'b1;
    endcase
  end

  assign o_error      = error_q;
  assign o_err_code   = code_q;
  assign o_step_phase = phase_q;
  assign o_dbg_state  = state_q;

  alt_eyemon_avmm_txn u_txn (
    .i_avmm_clk         (i_avmm_clk),
    .i_resetn           (i_resetn),
    .req_i              (txn_req),
    .rnw_i              (txn_rnw),
    .addr_i             (txn_addr),
    .wdata_i            (txn_wdata),
    .ack_o              (txn_ack),
    .rdata_o            (txn_rdata),
    .avmm_address_o     (o_avmm_maddress),
    .avmm_read_o        (o_avmm_mread),
    .avmm_write_o       (o_avmm_mwrite),
    .avmm_writedata_o   (o_avmm_mwritedata),
    .avmm_readdata_i    (i_avmm_mreaddata),
    .avmm_waitrequest_i (i_avmm_mwaitrequest)
  );

endmodule

// File: doc/alt_eyemon_sweep_ctrl.md
Name: alt_eyemon_sweep_ctrl

Overview:
- Avalon-MM master that drives the eye-monitor register slave to run a full phase sweep on one transceiver channel.
- On start, the sequence is:
  - enable the monitor (word 0 = 1);
  - step the phase (word 1) from 0 to PHASE_MAX, dwelling and handshaking each step with an external BER/error counter;
  - disable the monitor (word 0 = 0).
- Sits between the link-tuning controller (upstream) and the eye-monitor slave (downstream).

Parameters:
- CH_W, 3, channel address width; matches the slave's channel register width.
- PHASE_MAX, 63, last phase step swept; range 0..63 (6-bit field).
- DWELL_W, 16, width of the per-step dwell counter.
- POLL_LIMIT, 1024, maximum status reads per operation before timeout.

Ports:
- i_avmm_clk  in  1  clock
- i_resetn  in  1  synchronous active-low reset
- i_start  in  1  single-cycle request; ignored while o_busy
- i_channel  in  CH_W  channel to sweep; captured on accepted start
- i_dwell  in  DWELL_W  dwell cycles per step; captured on accepted start
- o_busy  out  1  sweep in progress
- o_done  out  1  one-cycle pulse at sweep end (success or error)
- o_error  out  1  last sweep failed; held until next accepted start
- o_err_code  out  3  1 = word-address error, 2 = channel-address error, 3 = poll timeout, 4 = readback mismatch
- o_step_valid  out  1  phase settled and dwell elapsed; held until ack
- o_step_phase  out  6  current phase step
- i_step_ack  in  1  consumer has sampled the step
- o_avmm_maddress  out  16  slave register: 0 = ctrl/status, 1 = channel, 2 = word, 3 = data
- o_avmm_mread  out  1
- o_avmm_mwrite  out  1
- o_avmm_mwritedata  out  16
- i_avmm_mreaddata  in  16
- i_avmm_mwaitrequest  in  1

Behaviour:
- Reset values:
  - all outputs 0;
  - state IDLE.
- Reset mid-sweep aborts immediately. No disable write is issued.
- Transaction rules:
  - Each Avalon access holds address, read/write and writedata stable until sampled with i_avmm_mwaitrequest = 0.
  - Read data is captured in that same cycle.
  - One access is outstanding at most; read and write are never asserted together.
  - Minimum 2 cycles per access, because the slave stalls the first cycle.
- Register operation RegOp(word, data), five accesses in order:
  1. write addr 1 = channel (zero-extended);
  2. write addr 2 = word;
  3. write addr 3 = data;
  4. write addr 0 = 0x0001 (start, write-op);
  5. POLL: read addr 0 repeatedly until bit 15 = 0.
- After POLL completes:
  - bit 14 set → error 1; bit 13 set → error 2; bit 14 has priority.
  - More than POLL_LIMIT reads → error 3.
- States: IDLE → EN_OP → STEP_OP → DWELL → REPORT → (next STEP_OP | DIS_OP) → DONE → IDLE; any error → ERR → DONE.
- EN_OP: RegOp(0, 1).
- STEP_OP: RegOp(1, phase).
- DWELL:
  - counts i_dwell cycles;
  - i_dwell = 0 means zero wait, so REPORT is entered the next cycle.
- REPORT:
  - o_step_valid = 1 with o_step_phase = phase;
  - leaves on i_step_ack;
  - an ack coincident with valid assertion counts;
  - an ack while not valid is ignored.
- Phase counter:
  - 6 bits, starts at 0, increments after each ack;
  - after the PHASE_MAX ack, goes to DIS_OP with no wrap.
- DIS_OP: RegOp(0, 0).
- DONE:
  - o_done pulses for 1 cycle, o_busy falls the same cycle;
  - a start is accepted in IDLE, no earlier than the cycle after DONE.
- ERR:
  - sets o_error and o_err_code;
  - issues no further accesses, including no disable write.
- o_busy rises the cycle after an accepted start.

Optional Feature:
- Macro: ALT_EYEMON_SWEEP_READBACK_EN.
- When defined, after each STEP_OP POLL the block performs:
  1. write addr 0 = 0x0003 (start, read-op);
  2. POLL;
  3. read addr 3.
- The read data must equal {10'b0, phase}; otherwise ERR with code 4.
- Without the macro, there are no readback accesses and code 4 never occurs.

Decomposition:
- Package alt_eyemon_sweep_pkg:
  - register address constants;
  - ctrl bit indices: START = 0, READOP = 1, ERR_CH = 13, ERR_WD = 14, BUSY = 15;
  - error-code constants;
  - state enum.
- Sub-module alt_eyemon_avmm_txn: single-access Avalon master engine.
  - Inputs: req, rnw, addr, wdata.
  - Outputs: ack pulse, rdata.
  - The sequencer FSM issues all accesses through it.

Test Plan:
- Basic sweep:
  - Stimulus: i_channel = 2, i_dwell = 4, PHASE_MAX = 3, slave busy for 5 polls; immediate ack.
  - Response: writes (1 = 2, 2 = 0, 3 = 1, 0 = 1), then four step ops with phases 0..3 on o_step_phase, then a disable op; o_done pulses, o_error = 0.
- Channel-address error:
  - Stimulus: slave returns status 0x2000 on the first poll.
  - Response: o_err_code = 2, o_done pulses, and no further writes occur.
- Poll timeout:
  - Stimulus: POLL_LIMIT = 8, busy bit stuck at 1.
  - Response: exactly 8 status reads, then o_err_code = 3.
- Step handshake:
  - Stimulus: hold i_step_ack low for 20 cycles at phase 1.
  - Response: o_step_valid stays 1, o_step_phase = 1, no Avalon activity; after ack, phase 2 is programmed.
- Start and reset corner cases:
  - Stimulus: i_start pulsed while busy, then reset asserted mid-POLL.
  - Response: the second start is ignored; after reset all outputs are 0, and a new sweep restarts cleanly from phase 0.
- Readback (with ALT_EYEMON_SWEEP_READBACK_EN):
  - Stimulus: slave returns data 0x0005 for phase 4.
  - Response: o_err_code = 4, and the sweep stops.
